ssd_scan_ctrl: RTL



---
 rtl/ssd_pkg.sv | 30 +++
 rtl/ssd_scan_timer.sv | 30 +++
 rtl/ssd_scan_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/ssd_pkg.sv
// Shared types for the seven-segment scan controller:
// scan states, digit-pair select codes and the display word.
package ssd_pkg;

    typedef enum logic [1:0] {
        BLANK_A,
        SHOW_A,
        BLANK_B,
        SHOW_B
    } state_e;

    localparam logic [1:0] SEG_EN_A = 2'b11;
    localparam logic [1:0] SEG_EN_B = 2'b00;

    typedef struct packed {
        logic [3:0] op;
        logic [3:0] rd1;
        logic [3:0] rd2;
        logic [3:0] wr;
    } disp_t;

    function automatic logic is_blank(input state_e s);
        return (s == BLANK_A) || (s == BLANK_B);
    endfunction

    function automatic logic is_phase_a(input state_e s);
        return (s == BLANK_A) || (s == SHOW_A);
    endfunction

endpackage

// File: rtl/ssd_scan_timer.sv
// Per-state cycle counter: clears on request, flags the last
// cycle of a state whose length is supplied by the caller.
module ssd_scan_timer #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic [W-1:0] len_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = clr_i ? '0 : cnt_q + W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == len_i - W'(1));

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Timed two-phase display scan with blanking gaps and a one-deep
// update buffer that is applied only at frame boundaries.
module ssd_scan_ctrl
    import ssd_pkg::*;
#(
    parameter int SCAN_DIV  = 1000,
    parameter int BLANK_CYC = 8
) (
    input  logic       clk_1M,
    input  logic       rst_n,
    input  logic       en,
    input  logic       upd_valid,
    output logic       upd_ready,
    input  logic [3:0] upd_opcode,
    input  logic [3:0] upd_rd1,
    input  logic [3:0] upd_rd2,
    input  logic [3:0] upd_wr,
    output logic [1:0] seg_en,
    output logic [3:0] hex_ab,
    output logic [3:0] hex_cd,
    output logic       blank,
    output logic       frame_done
);

    localparam int W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [W-1:0] LEN_BLANK = W'(BLANK_CYC);
    localparam logic [W-1:0] LEN_SHOW  = W'(SCAN_DIV - BLANK_CYC);

    state_e       state_q;
    state_e       state_d;
    disp_t        disp_q;
    disp_t        disp_d;
    disp_t        pend_q;
    disp_t        pend_d;
    logic         pend_full_q;
    logic         pend_full_d;
    logic [1:0]   seg_en_q;
    logic [3:0]   hex_ab_q;
    logic [3:0]   hex_cd_q;
    logic         blank_q;
    logic         frame_done_q;
    logic [W-1:0] len;
    logic         tc;
    logic         accept;
    logic         boundary;
    logic         load;
    logic         clr;
    logic         phase_a_d;

    assign len = is_blank(state_q) ? LEN_BLANK : LEN_SHOW;
    assign clr = !en || tc;

    ssd_scan_timer #(
        .W (W)
    ) u_timer (
        .clk_i  (clk_1M),
        .rst_ni (rst_n),
        .clr_i  (clr),
        .len_i  (len),
        .tc_o   (tc)
    );

    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = BLANK_A;
        end else if (tc) begin
            unique case (state_q)
                BLANK_A: state_d = SHOW_A;
                SHOW_A:  state_d = BLANK_B;
                BLANK_B: state_d = SHOW_B;
                SHOW_B:  state_d = BLANK_A;
                default: state_d = BLANK_A;
            endcase
        end
    end

    // Parking with en low counts as a boundary so a queued update still lands.
    always_comb begin
        boundary    = en && tc && (state_q == SHOW_B);
        load        = pend_full_q && (boundary || !en);
        accept      = upd_valid && !pend_full_q;
        disp_d      = load ? pend_q : disp_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        if (load) begin
            pend_full_d = 1'b0;
        end else if (accept) begin
            pend_d = '{op: upd_opcode, rd1: upd_rd1,
                       rd2: upd_rd2, wr: upd_wr};
            pend_full_d = 1'b1;
        end
        phase_a_d = is_phase_a(state_d);
    end

    always_ff @(posedge clk_1M) begin
        if (!rst_n) begin
            state_q      <= BLANK_A;
            disp_q       <= '0;
            pend_q       <= '0;
            pend_full_q  <= 1'b0;
            seg_en_q     <= SEG_EN_A;
            hex_ab_q     <= '0;
            hex_cd_q     <= '0;
            blank_q      <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            pend_full_q  <= pend_full_d;
            seg_en_q     <= phase_a_d ? SEG_EN_A : SEG_EN_B;
            hex_ab_q     <= phase_a_d ? disp_d.op : disp_d.rd1;
            hex_cd_q     <= phase_a_d ? disp_d.rd2 : disp_d.wr;
            blank_q      <= is_blank(state_d);
            frame_done_q <= boundary;
        end
    end

    assign upd_ready  = !pend_full_q;
    assign seg_en     = seg_en_q;
    assign hex_ab     = hex_ab_q;
    assign hex_cd     = hex_cd_q;
    assign blank      = blank_q;
    assign frame_done = frame_done_q;

endmodule
